ula_ctrl_fsm: RTL and testbench

ULA_CTRL_FSM -- requirements
Module: ula_ctrl_fsm

---
 rtl/ula_pkg.sv | 29 ++
 rtl/ula_8bits.sv | 28 ++
 rtl/ula_ctrl_fsm.sv | 141 ++++++++++++++
 tb/tb_ula_ctrl_fsm.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// rtl/ula_pkg.sv - shared opcode, state and width definitions for the ULA controller
package ula_pkg;

  localparam int DATA_W = 8;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_NOT  = 3'b010;
  localparam logic [2:0] OP_NAND = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Opcodes 110/111 are reserved and reported as errors
  function automatic logic is_valid_op(input logic [2:0] op);
    return (op <= OP_SUB);
  endfunction

  // Only arithmetic ops produce a meaningful carry
  function automatic logic is_arith_op(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/ula_8bits.sv
// rtl/ula_8bits.sv - combinational 8-bit ALU placed beside the controller at integration
module ula_8bits
  import ula_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       carry_in,
  input  logic [2:0] seletor,
  output logic [7:0] resultado,
  output logic       carry_out
);

  // Operation select; SUB reports borrow on carry_out
  always_comb begin
    resultado = 8'h00;
    carry_out = 1'b0;
    case (seletor)
      OP_AND:  resultado = a & b;
      OP_OR:   resultado = a | b;
      OP_NOT:  resultado = ~a;
      OP_NAND: resultado = ~(a & b);
      OP_ADD:  {carry_out, resultado} = {1'b0, a} + {1'b0, b} + {8'h00, carry_in};
      OP_SUB:  {carry_out, resultado} = {1'b0, a} - {1'b0, b} - {8'h00, carry_in};
      default: resultado = 8'h00;
    endcase
  end

endmodule

// File: rtl/ula_ctrl_fsm.sv
// rtl/ula_ctrl_fsm.sv - command/result sequencer for an external 8-bit ALU (option: ULA_CHAIN_EN)
module ula_ctrl_fsm
  import ula_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic              cmd_cin,
  input  logic              cmd_chain,
  output logic [DATA_W-1:0] ula_a,
  output logic [DATA_W-1:0] ula_b,
  output logic              ula_carry_in,
  output logic [2:0]        ula_seletor,
  input  logic [DATA_W-1:0] ula_resultado,
  input  logic              ula_carry_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_cout,
  output logic              res_zero,
  output logic              res_err
);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic [2:0]        op_q;
  logic              cin_q;
  logic              accept;
  logic              capture;
  logic              cin_sel;

  assign accept  = (state_q == ST_IDLE) && cmd_valid;
  assign capture = (state_q == ST_EXEC) && (cnt_q == 4'd0);

`ifdef ULA_CHAIN_EN
  logic carry_q;

  // Chained ADD/SUB continue from the carry of the previous arithmetic result
  assign cin_sel = (cmd_chain && is_arith_op(cmd_op)) ? carry_q : cmd_cin;

  // Stored carry follows every arithmetic capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      carry_q <= 1'b0;
    end else if (capture && is_arith_op(op_q)) begin
      carry_q <= ula_carry_out;
    end
  end
`else
  logic chain_unused;
  assign chain_unused = cmd_chain;
  assign cin_sel      = cmd_cin;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake decode
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    res_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_d = is_valid_op(cmd_op) ? ST_EXEC : ST_DONE;
        end
      end
      ST_EXEC: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand latch, settle counter and result capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= 4'd0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 3'b000;
      cin_q    <= 1'b0;
      res_data <= '0;
      res_cout <= 1'b0;
      res_zero <= 1'b0;
      res_err  <= 1'b0;
    end else if (accept) begin
      if (is_valid_op(cmd_op)) begin
        a_q   <= cmd_a;
        b_q   <= cmd_b;
        op_q  <= cmd_op;
        cin_q <= cin_sel;
        cnt_q <= 4'(SETTLE_CYCLES - 1);
      end else begin
        // Reserved opcode: ALU drive is left untouched, error result goes out directly
        res_data <= '0;
        res_cout <= 1'b0;
        res_zero <= 1'b0;
        res_err  <= 1'b1;
      end
    end else if (state_q == ST_EXEC) begin
      if (capture) begin
        res_data <= ula_resultado;
        res_cout <= is_arith_op(op_q) ? ula_carry_out : 1'b0;
        res_zero <= (ula_resultado == '0);
        res_err  <= 1'b0;
      end else begin
        cnt_q <= cnt_q - 4'd1;
      end
    end
  end

  assign ula_a        = a_q;
  assign ula_b        = b_q;
  assign ula_carry_in = cin_q;
  assign ula_seletor  = op_q;

endmodule

// File: tb/tb_ula_ctrl_fsm.sv
// tb/tb_ula_ctrl_fsm.sv - directed scoreboard bench for ula_ctrl_fsm with ula_8bits ALUs
module tb_ula_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] cmd_op = 3'b000;
  logic [7:0] cmd_a = 8'h00, cmd_b = 8'h00;
  logic       cmd_cin = 1'b0, cmd_chain = 1'b0;
  logic       cmd_valid1 = 1'b0, cmd_valid3 = 1'b0;
  logic       res_ready1 = 1'b0, res_ready3 = 1'b0;

  logic       cmd_ready1, res_valid1, res_cout1, res_zero1, res_err1;
  logic [7:0] res_data1, ula_a1, ula_b1, alu_r1;
  logic       ula_cin1, alu_co1;
  logic [2:0] ula_sel1;

  logic       cmd_ready3, res_valid3, res_cout3, res_zero3, res_err3;
  logic [7:0] res_data3, ula_a3, ula_b3, alu_r3;
  logic       ula_cin3, alu_co3;
  logic [2:0] ula_sel3;

  typedef struct packed {
    logic [7:0] data;
    logic       cout;
    logic       zero;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ula_ctrl_fsm #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin), .cmd_chain(cmd_chain),
    .ula_a(ula_a1), .ula_b(ula_b1), .ula_carry_in(ula_cin1), .ula_seletor(ula_sel1),
    .ula_resultado(alu_r1), .ula_carry_out(alu_co1),
    .res_valid(res_valid1), .res_ready(res_ready1),
    .res_data(res_data1), .res_cout(res_cout1), .res_zero(res_zero1), .res_err(res_err1)
  );

  ula_8bits u_alu1 (
    .a(ula_a1), .b(ula_b1), .carry_in(ula_cin1), .seletor(ula_sel1),
    .resultado(alu_r1), .carry_out(alu_co1)
  );

  ula_ctrl_fsm #(.SETTLE_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin), .cmd_chain(cmd_chain),
    .ula_a(ula_a3), .ula_b(ula_b3), .ula_carry_in(ula_cin3), .ula_seletor(ula_sel3),
    .ula_resultado(alu_r3), .ula_carry_out(alu_co3),
    .res_valid(res_valid3), .res_ready(res_ready3),
    .res_data(res_data3), .res_cout(res_cout3), .res_zero(res_zero3), .res_err(res_err3)
  );

  ula_8bits u_alu3 (
    .a(ula_a3), .b(ula_b3), .carry_in(ula_cin3), .seletor(ula_sel3),
    .resultado(alu_r3), .carry_out(alu_co3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic co, input logic z, input logic e);
    exp_t x;
    x.data = d; x.cout = co; x.zero = z; x.err = e;
    sb.push_back(x);
  endtask

  task automatic send(input bit sel3, input logic [2:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic cin, input logic chain);
    chk("cmd_ready_idle", {31'd0, sel3 ? cmd_ready3 : cmd_ready1}, 32'd1);
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_cin = cin; cmd_chain = chain;
    if (sel3) cmd_valid3 = 1'b1;
    else      cmd_valid1 = 1'b1;
    tick();
    cmd_valid1 = 1'b0;
    cmd_valid3 = 1'b0;
  endtask

  task automatic get_result(input bit sel3, input int exp_lat, input bit early_low, input string tag);
    int   lat = 0;
    bit   seen = 1'b0;
    exp_t e;
    if (early_low) chk({tag, "_early_valid"}, {31'd0, sel3 ? res_valid3 : res_valid1}, 32'd0);
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      lat++;
      if ((sel3 ? res_valid3 : res_valid1) === 1'b1) seen = 1'b1;
    end
    chk({tag, "_seen"}, {31'd0, seen}, 32'd1);
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_sb_nonempty"}, {31'd0, sb.size() != 0}, 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_data"}, {24'd0, sel3 ? res_data3 : res_data1}, {24'd0, e.data});
      chk({tag, "_cout"}, {31'd0, sel3 ? res_cout3 : res_cout1}, {31'd0, e.cout});
      chk({tag, "_zero"}, {31'd0, sel3 ? res_zero3 : res_zero1}, {31'd0, e.zero});
      chk({tag, "_err"},  {31'd0, sel3 ? res_err3  : res_err1},  {31'd0, e.err});
    end
  endtask

  task automatic release_result(input bit sel3, input string tag);
    if (sel3) res_ready3 = 1'b1;
    else      res_ready1 = 1'b1;
    tick();
    res_ready1 = 1'b0;
    res_ready3 = 1'b0;
    chk({tag, "_valid_drop"}, {31'd0, sel3 ? res_valid3 : res_valid1}, 32'd0);
    chk({tag, "_ready_back"}, {31'd0, sel3 ? cmd_ready3 : cmd_ready1}, 32'd1);
  endtask

  initial begin
    bit hold_ok;
    bit pulse_seen;
    logic [7:0] chain_exp;
    logic       chain_zero;

    // Reset state
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_res_valid", {31'd0, res_valid1}, 32'd0);
    chk("rst_res_data",  {24'd0, res_data1}, 32'd0);
    chk("rst_ula_drive", {13'd0, ula_a1, ula_b1, ula_cin1, ula_sel1}, 32'd0);
    chk("rst_res_flags", {29'd0, res_cout1, res_zero1, res_err1}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_cmd_ready", {31'd0, cmd_ready1}, 32'd1);

    // AND CC & AA
    push(8'h88, 1'b0, 1'b0, 1'b0);
    send(1'b0, 3'b000, 8'hCC, 8'hAA, 1'b0, 1'b0);
    get_result(1'b0, 1, 1'b1, "and");
    chk("and_cmd_ready_done", {31'd0, cmd_ready1}, 32'd0);
    release_result(1'b0, "and");

    // ADD FF + 01 wraps with carry
    push(8'h00, 1'b1, 1'b1, 1'b0);
    send(1'b0, 3'b100, 8'hFF, 8'h01, 1'b0, 1'b0);
    get_result(1'b0, 1, 1'b1, "add_wrap");
    release_result(1'b0, "add_wrap");

    // Chained ADD 00 + 00 consumes stored carry when chaining is built in
`ifdef ULA_CHAIN_EN
    chain_exp = 8'h01; chain_zero = 1'b0;
`else
    chain_exp = 8'h00; chain_zero = 1'b1;
`endif
    push(chain_exp, 1'b0, chain_zero, 1'b0);
    send(1'b0, 3'b100, 8'h00, 8'h00, 1'b0, 1'b1);
    get_result(1'b0, 1, 1'b1, "add_chain");
    release_result(1'b0, "add_chain");

    // Reserved opcode: error result, ALU drive keeps the previous ADD
    push(8'h00, 1'b0, 1'b0, 1'b1);
    send(1'b0, 3'b111, 8'h12, 8'h00, 1'b0, 1'b0);
    get_result(1'b0, 1, 1'b0, "invalid");
    chk("invalid_seletor_kept", {29'd0, ula_sel1}, 32'd4);
    chk("invalid_ula_a_kept",   {24'd0, ula_a1}, 32'd0);
    release_result(1'b0, "invalid");

    // NAND with backpressure and an ignored second command
    push(8'hFF, 1'b0, 1'b0, 1'b0);
    send(1'b0, 3'b011, 8'hAA, 8'h55, 1'b0, 1'b0);
    get_result(1'b0, 1, 1'b1, "nand");
    cmd_op = 3'b000; cmd_a = 8'h01; cmd_b = 8'h02;
    cmd_valid1 = 1'b1;
    hold_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (res_data1 !== 8'hFF || res_valid1 !== 1'b1 || cmd_ready1 !== 1'b0) hold_ok = 1'b0;
    end
    chk("nand_hold_stable", {31'd0, hold_ok}, 32'd1);
    cmd_valid1 = 1'b0;
    chk("nand_second_ignored", {24'd0, ula_a1}, 32'hAA);
    release_result(1'b0, "nand");

    // SUB 10 - 01
    push(8'h0F, 1'b0, 1'b0, 1'b0);
    send(1'b0, 3'b101, 8'h10, 8'h01, 1'b0, 1'b0);
    get_result(1'b0, 1, 1'b1, "sub");
    release_result(1'b0, "sub");

    // Three-cycle settle: OR F0 | 0F
    push(8'hFF, 1'b0, 1'b0, 1'b0);
    send(1'b1, 3'b001, 8'hF0, 8'h0F, 1'b0, 1'b0);
    get_result(1'b1, 3, 1'b1, "or_settle3");
    release_result(1'b1, "or_settle3");

    // Reset while executing aborts the operation
    send(1'b1, 3'b100, 8'h01, 8'h01, 1'b0, 1'b0);
    tick();
    rst_n = 1'b0;
    tick();
    chk("abort_res_valid", {31'd0, res_valid3}, 32'd0);
    chk("abort_cmd_ready", {31'd0, cmd_ready3}, 32'd1);
    chk("abort_res_data",  {24'd0, res_data3}, 32'd0);
    chk("abort_ula_drive", {13'd0, ula_a3, ula_b3, ula_cin3, ula_sel3}, 32'd0);
    chk("abort_res_flags", {29'd0, res_cout3, res_zero3, res_err3}, 32'd0);
    rst_n = 1'b1;
    pulse_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (res_valid3 !== 1'b0) pulse_seen = 1'b1;
    end
    chk("abort_no_result", {31'd0, pulse_seen}, 32'd0);
    chk("sb_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
